fetch_npc: RTL and testbench
============================

FETCH_NPC -- requirements
Module: fetch_npc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value driven on npc while rst is high.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc  input  32  current fetch address from the PC register.
REQ-005 instr  input  32  instruction word read from instruction memory at pc, same cycle.
REQ-006 stall  input  1  ID hazard stall; hold pc and the IF/ID register.
REQ-007 br_taken  input  1  branch resolved taken in EX.
REQ-008 br_target  input  32  branch target address.
REQ-009 jump  input  1  jump decoded in ID.
REQ-010 jump_target  input  32  jump target address.
REQ-011 npc  output  32  next PC, fed back to the PC register input.
REQ-012 ifid_pc4  output  32  registered pc+4 of the instruction in ID.
REQ-013 ifid_instr  output  32  registered instruction in ID.
REQ-014 ifid_valid  output  1  ID slot holds a real instruction (0 = bubble).
REQ-015 fetch_cnt  output  32  count of instructions accepted into ID.

Function
REQ-016 npc SHALL be combinational, with priority: rst -> RESET_PC; br_taken -> br_target; jump -> jump_target; stall -> pc; else pc+4.
REQ-017 Redirect targets SHALL have bits [1:0] forced to 0 on npc; pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 br_taken SHALL override jump and stall in the same cycle; jump SHALL override stall.
REQ-019 The block SHALL contain a 3-state FSM: BOOT, RUN, HOLD.
REQ-020 BOOT: entered on reset; one cycle after rst deasserts, IF/ID loads a bubble (ifid_valid=0); next state RUN, or HOLD if stall.
REQ-021 RUN: on each clock edge without stall or redirect, IF/ID SHALL load pc+4, instr, and ifid_valid=1, and fetch_cnt SHALL increment by 1.
REQ-022 RUN with stall (and no redirect): IF/ID and fetch_cnt SHALL hold; next state HOLD.
REQ-023 HOLD: IF/ID and fetch_cnt SHALL hold while stall=1; on stall=0, go to RUN and load IF/ID on that edge as in REQ-021.
REQ-024 Redirect (br_taken or jump) in any state SHALL flush IF/ID on that edge: ifid_valid=0, ifid_instr=0, ifid_pc4 held; fetch_cnt held; next state RUN.
REQ-025 A redirect SHALL take effect on the same cycle as a stall; the flush has priority over the hold.
REQ-026 Latency: an instruction presented on instr SHALL appear on ifid_instr one clock edge later.
REQ-027 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 Inputs SHALL not be registered except through IF/ID; there SHALL be no other internal pipeline depth.

Reset
REQ-029 On rst=1, asynchronously: state=BOOT, ifid_pc4=0, ifid_instr=0, ifid_valid=0, fetch_cnt=0, npc=RESET_PC.
REQ-030 Asserting rst mid-operation, including during HOLD or a redirect, SHALL abort it immediately with no residual effect after release.

Verification
REQ-031 Reset release with pc=0, instr=32'h2008_0005, no stall: first edge ifid_valid=0 (BOOT); next edge ifid_instr=32'h2008_0005, ifid_pc4=4, fetch_cnt=1.
REQ-032 pc=32'h0000_FC00 in RUN: npc=32'h0000_FC04; pc=32'hFFFF_FFFC: npc=32'h0000_0000.
REQ-033 stall held 3 cycles in RUN with pc=32'h0000_FC00: npc=32'h0000_FC00 throughout; IF/ID and fetch_cnt unchanged; load resumes on the first edge after stall=0.
REQ-034 br_taken=1, br_target=32'h7800_FC02, jump=1, stall=1 together: npc=32'h7800_FC00; next edge ifid_valid=0; fetch_cnt unchanged.
REQ-035 jump=1, jump_target=32'h0040_0010 in RUN: npc=32'h0040_0010; next edge ifid_valid=0, state RUN.
REQ-036 rst pulsed for 3 ns mid-HOLD, asynchronous to clk: all outputs per REQ-029 before the next clock edge; BOOT sequence repeats after release.

Source files
------------

// File: rtl/fetch_npc.sv
// IF-stage next-PC selection and IF/ID pipeline register.
// Redirects flush IF/ID; stalls hold it; a small BOOT/RUN/HOLD FSM sequences fetch after reset.
module fetch_npc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] npc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc4;
  logic        redirect;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic [31:0] fetch_cnt_q;

  assign pc4      = pc + 32'd4;
  assign redirect = br_taken | jump;

  // Redirect targets are word-aligned by dropping the low two bits.
  always_comb begin
    npc = pc4;
    if (rst)           npc = RESET_PC;
    else if (br_taken) npc = {br_target[31:2], 2'b00};
    else if (jump)     npc = {jump_target[31:2], 2'b00};
    else if (stall)    npc = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else if (redirect) begin
      // Flush wins over any stall or boot bubble; pc4 is deliberately left as-is.
      state_q      <= RUN;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          ifid_instr_q <= '0;
          ifid_valid_q <= 1'b0;
          state_q      <= stall ? HOLD : RUN;
        end
        RUN, HOLD: begin
          if (stall) begin
            state_q <= HOLD;
          end else begin
            state_q      <= RUN;
            ifid_pc4_q   <= pc4;
            ifid_instr_q <= instr;
            ifid_valid_q <= 1'b1;
            fetch_cnt_q  <= fetch_cnt_q + 32'd1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_npc.sv
// Directed bench for fetch_npc: next-PC priority, IF/ID load/hold/flush, and async reset.
module tb_fetch_npc;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr, br_target, jump_target;
  logic        stall, br_taken, jump;
  logic [31:0] npc, ifid_pc4, ifid_instr, fetch_cnt;
  logic        ifid_valid;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  fetch_npc #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jump(jump),
    .jump_target(jump_target), .npc(npc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] p4, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, ".instr"}, ifid_instr, ins);
    chk({tag, ".pc4"},   ifid_pc4,   p4);
    chk({tag, ".cnt"},   fetch_cnt,  cnt);
  endtask

  initial begin
    rst = 1'b1; pc = '0; instr = 32'h2008_0005; stall = 1'b0;
    br_taken = 1'b0; br_target = '0; jump = 1'b0; jump_target = '0;

    // Reset state
    tick(); tick();
    chk("rst_npc", npc, RPC);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);

    // Release: BOOT bubble then first real load
    rst = 1'b0; #1;
    chk("run_npc0", npc, 32'h0000_0004);
    tick();
    chk_ifid("boot", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_ifid("first", 1'b1, 32'h2008_0005, 32'h4, 32'h1);

    // Sequential fetch and pc+4 wrap
    pc = 32'h0000_FC00; instr = 32'h1111_1111; #1;
    chk("npc_fc04", npc, 32'h0000_FC04);
    tick();
    chk_ifid("ld_fc00", 1'b1, 32'h1111_1111, 32'h0000_FC04, 32'h2);
    pc = 32'hFFFF_FFFC; instr = 32'h2222_2222; #1;
    chk("npc_wrap", npc, 32'h0000_0000);
    tick();
    chk_ifid("ld_wrap", 1'b1, 32'h2222_2222, 32'h0, 32'h3);

    // Stall for three edges: npc=pc, IF/ID and count frozen
    pc = 32'h0000_FC00; instr = 32'hAAAA_AAAA; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_npc", npc, 32'h0000_FC00);
      tick();
      chk_ifid("stall", 1'b1, 32'h2222_2222, 32'h0, 32'h3);
    end
    stall = 1'b0; instr = 32'hBBBB_BBBB; #1;
    chk("unstall_npc", npc, 32'h0000_FC04);
    tick();
    chk_ifid("resume", 1'b1, 32'hBBBB_BBBB, 32'h0000_FC04, 32'h4);

    // Branch beats jump and stall; target aligned
    br_taken = 1'b1; br_target = 32'h7800_FC02; jump = 1'b1; jump_target = 32'h0000_0040;
    stall = 1'b1; instr = 32'hCCCC_CCCC; #1;
    chk("br_npc", npc, 32'h7800_FC00);
    tick();
    chk_ifid("br_flush", 1'b0, 32'h0, 32'h0000_FC04, 32'h4);
    br_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    pc = 32'h0000_0100; instr = 32'hDDDD_DDDD;
    tick();
    chk_ifid("after_br", 1'b1, 32'hDDDD_DDDD, 32'h0000_0104, 32'h5);

    // Jump in RUN, then normal load proves state RUN
    jump = 1'b1; jump_target = 32'h0040_0010; instr = 32'hEEEE_EEEE; #1;
    chk("jmp_npc", npc, 32'h0040_0010);
    tick();
    chk_ifid("jmp_flush", 1'b0, 32'h0, 32'h0000_0104, 32'h5);
    jump = 1'b0; pc = 32'h0040_0010; instr = 32'h1234_5678;
    tick();
    chk_ifid("after_jmp", 1'b1, 32'h1234_5678, 32'h0040_0014, 32'h6);

    // Jump beats stall, unaligned target masked
    pc = 32'h0000_0300; jump = 1'b1; jump_target = 32'h0000_0203; stall = 1'b1; #1;
    chk("jmp_stall_npc", npc, 32'h0000_0200);
    jump = 1'b0; #1;
    chk("stall_only_npc", npc, 32'h0000_0300);

    // Enter HOLD, then an async 3 ns reset pulse between edges
    tick();
    chk_ifid("hold", 1'b1, 32'h1234_5678, 32'h0040_0014, 32'h6);
    #1 rst = 1'b1;
    #1;
    chk("arst_npc", npc, RPC);
    chk_ifid("arst", 1'b0, 32'h0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    stall = 1'b0; pc = 32'h0000_0000; instr = 32'h2008_0005;
    tick();
    chk_ifid("reboot", 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_ifid("reload", 1'b1, 32'h2008_0005, 32'h4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
